// File: rtl/fetch_pkg.sv
// Shared fetch/decode types and constants.
// Imported by the fetch unit and the control decoder.
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [31:0] word_pc(
    input logic [29:0] w
  );
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer between the store read port and the output register.
// in_ready reports room for a read issued this cycle (it lands next cycle).
`timescale 1ns/1ps
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_word,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  logic        full;
  logic        full_next;
  logic [31:0] word_q;
  logic [31:0] pc_q;

  always_comb begin
    full_next = 1'b0;
    if (!flush) begin
      if (out_ready) full_next = full & in_valid;
      else           full_next = full | in_valid;
    end
    in_ready  = !full_next;
    out_valid = full | in_valid;
    out_word  = full ? word_q : in_word;
    out_pc    = full ? pc_q : in_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      word_q <= '0;
      pc_q   <= '0;
    end else begin
      full <= full_next;
      // capture when the entry is being drained or when the output stalls
      if (in_valid && (full == out_ready)) begin
        word_q <= in_word;
        pc_q   <= in_pc;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: program store, PC/FSM and output register
// presenting words to the decoder over valid/ready.
`timescale 1ns/1ps
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [31:0]       loadData,
  input  logic              start,
  input  logic              halt,
  output logic [31:0]       instrWord,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [31:0]       pc,
  input  logic              branchTaken,
  input  logic [31:0]       branchTarget,
  output logic              busy,
  output logic              done,
  output logic              alignErr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] RESET_WORD = RESET_PC[ADDR_W+1:2];

  logic [31:0]       mem [DEPTH];
  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld;
  logic [31:0]       rd_word;
  logic [31:0]       rd_pc;

  logic        accept;
  logic        out_adv;
  logic        redirect;
  logic        misalign;
  logic        go;
  logic        halt_hit;
  logic        issue;
  logic        sk_flush;
  logic        sk_room;
  logic        sk_valid;
  logic [31:0] sk_word;
  logic [31:0] sk_pc;
  logic        unused_bits;

  assign unused_bits = ^branchTarget[31:ADDR_W+2];

  assign accept   = instrValid & instrReady;
  assign out_adv  = !instrValid | instrReady;
  assign redirect = (state == RUN) && accept
                  && branchTaken && !halt;
  assign misalign = redirect && (branchTarget[1:0] != 2'b00);
  assign go       = !halt && start
                  && (((state == IDLE) && !loadEn)
                  || (state == DONE));
  assign halt_hit = rd_vld && (rd_word == HALT_WORD);
  assign sk_flush = halt | redirect | go;

  always_comb begin
    issue = 1'b0;
    if (halt || go) issue = 1'b0;
    else if (redirect) issue = !misalign;
    else issue = (state == RUN) && sk_room && !halt_hit;
  end

  assign rd_addr = redirect ? branchTarget[ADDR_W+1:2]
                            : fetch_addr;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // store contents survive reset
  always_ff @(posedge clk) begin
    if (loadEn && (state == IDLE)) mem[loadAddr] <= loadData;
    if (issue) rd_word <= mem[rd_addr];
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (sk_flush),
    .in_valid  (rd_vld & !halt_hit),
    .in_word   (rd_word),
    .in_pc     (rd_pc),
    .in_ready  (sk_room),
    .out_valid (sk_valid),
    .out_word  (sk_word),
    .out_pc    (sk_pc),
    .out_ready (out_adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_addr <= RESET_WORD;
      rd_vld     <= 1'b0;
      rd_pc      <= RESET_PC;
      instrValid <= 1'b0;
      instrWord  <= '0;
      pc         <= RESET_PC;
      alignErr   <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        rd_pc      <= word_pc(30'(rd_addr));
        fetch_addr <= rd_addr + ADDR_W'(1);
      end
      if (halt) begin
        state      <= IDLE;
        instrValid <= 1'b0;
      end else if (misalign) begin
        state      <= DONE;
        alignErr   <= 1'b1;
        instrValid <= 1'b0;
      end else if (redirect) begin
        instrValid <= 1'b0;
      end else if (go) begin
        state      <= RUN;
        fetch_addr <= RESET_WORD;
        alignErr   <= 1'b0;
        instrValid <= 1'b0;
      end else begin
        if (out_adv) begin
          instrValid <= sk_valid;
          if (sk_valid) begin
            instrWord <= sk_word;
            pc        <= sk_pc;
          end
        end
        // halt sentinel is swallowed; queued words still drain
        if ((state == RUN) && halt_hit) state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized
// run checked against an expected-PC-stream model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_load_en = 0;
  logic [7:0]  a_load_addr = '0;
  logic [31:0] a_load_data = '0;
  logic        a_start = 0, a_halt = 0, a_ready = 0, a_br = 0;
  logic [31:0] a_tgt = '0;
  logic [31:0] a_word, a_pc;
  logic        a_valid, a_busy, a_done, a_err;

  logic        b_load_en = 0;
  logic [1:0]  b_load_addr = '0;
  logic [31:0] b_load_data = '0;
  logic        b_start = 0, b_halt = 0, b_ready = 0, b_br = 0;
  logic [31:0] b_tgt = '0;
  logic [31:0] b_word, b_pc;
  logic        b_valid, b_busy, b_done, b_err;

  int total = 0;
  int bad = 0;
  logic [31:0] img [256];
  logic [31:0] bimg [4];

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .loadEn(a_load_en), .loadAddr(a_load_addr),
    .loadData(a_load_data),
    .start(a_start), .halt(a_halt),
    .instrWord(a_word), .instrValid(a_valid),
    .instrReady(a_ready), .pc(a_pc),
    .branchTaken(a_br), .branchTarget(a_tgt),
    .busy(a_busy), .done(a_done), .alignErr(a_err)
  );

  instr_fetch_unit #(.ADDR_W(2), .RESET_PC(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .loadEn(b_load_en), .loadAddr(b_load_addr),
    .loadData(b_load_data),
    .start(b_start), .halt(b_halt),
    .instrWord(b_word), .instrValid(b_valid),
    .instrReady(b_ready), .pc(b_pc),
    .branchTaken(b_br), .branchTarget(b_tgt),
    .busy(b_busy), .done(b_done), .alignErr(b_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_a(input logic [7:0] ad,
                        input logic [31:0] d);
    a_load_en = 1; a_load_addr = ad; a_load_data = d;
    img[ad] = d;
    tick();
    a_load_en = 0;
  endtask

  task automatic start_a();
    a_start = 1; tick(); a_start = 0;
  endtask

  task automatic halt_a();
    a_halt = 1; tick(); a_halt = 0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (a_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", a_valid);
    end
    total++;
    if (a_pc !== 32'h0 || a_word !== 32'h0) begin
      bad++;
      $display("FAIL reset_pc_word got=%h/%h want=0/0", a_pc, a_word);
    end
    total++;
    if ({a_busy, a_done, a_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {a_busy, a_done, a_err});
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    logic        ev [6];
    logic [31:0] ep [6];
    ev = '{0, 0, 1, 1, 1, 0};
    ep = '{0, 0, 32'h0, 32'h4, 32'h8, 0};
    load_a(0, 32'h0022_1820);
    load_a(1, 32'h8C43_0004);
    load_a(2, 32'hAC43_0008);
    load_a(3, HALT);
    a_ready = 1;
    start_a();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (a_valid !== ev[i]) begin
        bad++;
        $display("FAIL basic_valid[%0d] got=%b want=%b",
                 i, a_valid, ev[i]);
      end else if (ev[i]) begin
        total++;
        if (a_pc !== ep[i] || a_word !== img[ep[i][9:2]]) begin
          bad++;
          $display("FAIL basic_word[%0d] got=%h/%h want=%h/%h",
                   i, a_pc, a_word, ep[i], img[ep[i][9:2]]);
        end
      end
      tick();
    end
    total++;
    if (a_done !== 1'b1 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done got=%b/%b want=1/0", a_done, a_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    logic [31:0] hp, hw, e;
    int stall = 0;
    int acc = 0;
    bit once = 0;
    q = '{32'h0, 32'h4, 32'h8};
    a_ready = 1;
    start_a();
    for (int c = 0; c < 25 && !(a_done && !a_valid); c++) begin
      if (a_valid && a_pc == 32'h4 && !once) begin
        once = 1; stall = 3; a_ready = 0;
        hp = a_pc; hw = a_word;
      end else if (stall > 0) begin
        total++;
        if (a_valid !== 1'b1 || a_pc !== hp || a_word !== hw) begin
          bad++;
          $display("FAIL bp_hold got=%b/%h/%h want=1/%h/%h",
                   a_valid, a_pc, a_word, hp, hw);
        end
        stall--;
        a_ready = (stall == 0);
      end
      if (a_valid && a_ready) begin
        acc++;
        e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        total++;
        if (a_pc !== e || a_word !== img[e[9:2]]) begin
          bad++;
          $display("FAIL bp_accept got=%h/%h want=%h/%h",
                   a_pc, a_word, e, img[e[9:2]]);
        end
      end
      tick();
    end
    total++;
    if (acc != 3 || !a_done) begin
      bad++;
      $display("FAIL bp_count got=%0d done=%b want=3 done=1",
               acc, a_done);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] q[$];
    logic [31:0] e;
    int since = -1;
    bit seen8 = 0;
    q = '{32'h0, 32'h4, 32'h20};
    halt_a();
    load_a(8, 32'h0109_4020);
    load_a(9, HALT);
    a_ready = 1;
    start_a();
    for (int c = 0; c < 25 && !(a_done && !a_valid); c++) begin
      if (since >= 0) since++;
      if (since == 1) begin
        total++;
        if (a_valid !== 1'b0) begin
          bad++; $display("FAIL br_bubble got=%b want=0", a_valid);
        end
      end
      if (since == 2) begin
        total++;
        if (a_valid !== 1'b1 || a_pc !== 32'h20) begin
          bad++;
          $display("FAIL br_target got=%b/%h want=1/00000020",
                   a_valid, a_pc);
        end
      end
      if (a_valid && a_pc == 32'h8) seen8 = 1;
      a_br = a_valid && a_pc == 32'h4;
      a_tgt = 32'h20;
      if (a_valid && a_ready) begin
        if (a_br) since = 0;
        e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        total++;
        if (a_pc !== e || a_word !== img[e[9:2]]) begin
          bad++;
          $display("FAIL br_accept got=%h/%h want=%h/%h",
                   a_pc, a_word, e, img[e[9:2]]);
        end
      end
      tick();
    end
    a_br = 0;
    total++;
    if (seen8 || q.size() != 0 || !a_done) begin
      bad++;
      $display("FAIL br_end got=seen8:%b left:%0d done:%b want=0/0/1",
               seen8, q.size(), a_done);
    end
  endtask

  task automatic test_misalign();
    bit hit = 0;
    a_ready = 1;
    start_a();
    for (int c = 0; c < 10 && !hit; c++) begin
      if (a_valid) hit = 1;
      else tick();
    end
    total++;
    if (!hit || a_pc !== 32'h0) begin
      bad++;
      $display("FAIL mis_first got=%b/%h want=1/0", hit, a_pc);
    end
    a_br = 1; a_tgt = 32'h22;
    tick();
    a_br = 0;
    total++;
    if ({a_err, a_done, a_valid, a_busy} !== 4'b1100) begin
      bad++;
      $display("FAIL mis_flags got=%b want=1100",
               {a_err, a_done, a_valid, a_busy});
    end
    start_a();
    total++;
    if (a_err !== 1'b0 || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL mis_clear got=%b/%b want=0/1", a_err, a_busy);
    end
    tick(); tick();
    total++;
    if (a_valid !== 1'b1 || a_pc !== 32'h0) begin
      bad++;
      $display("FAIL mis_restart got=%b/%h want=1/0", a_valid, a_pc);
    end
    for (int c = 0; c < 20 && !(a_done && !a_valid); c++) tick();
  endtask

  task automatic test_halt();
    a_ready = 1;
    start_a();
    tick(); tick();
    a_ready = 0;
    total++;
    if (a_valid !== 1'b1) begin
      bad++; $display("FAIL halt_pre got=%b want=1", a_valid);
    end
    halt_a();
    total++;
    if ({a_valid, a_busy, a_done} !== 3'b000) begin
      bad++;
      $display("FAIL halt_idle got=%b want=000",
               {a_valid, a_busy, a_done});
    end
    a_ready = 1;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      bimg[i] = $urandom & 32'h7FFF_FFFF;
      b_load_en = 1; b_load_addr = 2'(i); b_load_data = bimg[i];
      tick();
    end
    b_load_en = 0;
    b_ready = 1;
    b_start = 1; tick(); b_start = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i < 2) begin
        if (b_valid !== 1'b0) begin
          bad++; $display("FAIL wrap_lat[%0d] got=%b want=0", i, b_valid);
        end
      end else begin
        e = 32'(((i - 2) * 4) % 16);
        if (b_valid !== 1'b1 || b_pc !== e
            || b_word !== bimg[(i - 2) % 4]) begin
          bad++;
          $display("FAIL wrap[%0d] got=%b/%h/%h want=1/%h/%h", i,
                   b_valid, b_pc, b_word, e, bimg[(i - 2) % 4]);
        end
      end
      tick();
    end
    b_halt = 1; tick(); b_halt = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] q[$];
    logic [31:0] e;
    a_ready = 1;
    start_a();
    tick(); tick();
    total++;
    if (a_valid !== 1'b1) begin
      bad++; $display("FAIL ar_pre got=%b want=1", a_valid);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({a_valid, a_busy, a_done, a_err} !== 4'b0000
        || a_pc !== 32'h0 || a_word !== 32'h0) begin
      bad++;
      $display("FAIL ar_reset got=%b/%h/%h want=0000/0/0",
               {a_valid, a_busy, a_done, a_err}, a_pc, a_word);
    end
    tick();
    rst_n = 1;
    tick();
    q = '{32'h0, 32'h4, 32'h8};
    start_a();
    for (int c = 0; c < 20 && !(a_done && !a_valid); c++) begin
      if (a_valid && a_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        total++;
        if (a_pc !== e || a_word !== img[e[9:2]]) begin
          bad++;
          $display("FAIL ar_replay got=%h/%h want=%h/%h",
                   a_pc, a_word, e, img[e[9:2]]);
        end
      end
      tick();
    end
    total++;
    if (q.size() != 0 || !a_done) begin
      bad++;
      $display("FAIL ar_end got=left:%0d done:%b want=0/1",
               q.size(), a_done);
    end
  endtask

  task automatic test_random();
    int len, nbr, acc;
    logic [31:0] exp_pc, tgt, hp, hw, n1, n2;
    bit hold, fin;
    halt_a();
    len = $urandom_range(12, 40);
    for (int i = 0; i < len; i++)
      load_a(8'(i), $urandom & 32'h7FFF_FFFF);
    load_a(8'(len), HALT);
    exp_pc = 0; nbr = 0; acc = 0; hold = 0; fin = 0;
    a_ready = 1;
    start_a();
    for (int c = 0; c < 3000; c++) begin
      if (a_done && !a_valid) begin fin = 1; break; end
      if (hold) begin
        total++;
        if (a_valid !== 1'b1 || a_pc !== hp || a_word !== hw) begin
          bad++;
          $display("FAIL rnd_hold got=%b/%h/%h want=1/%h/%h",
                   a_valid, a_pc, a_word, hp, hw);
        end
      end
      a_ready = ($urandom_range(0, 9) < 7);
      a_tgt = $urandom;
      a_br = 1'($urandom_range(0, 1));
      if (a_valid && a_ready) begin
        acc++;
        total++;
        if (a_pc !== exp_pc || a_word !== img[exp_pc[9:2]]) begin
          bad++;
          $display("FAIL rnd_accept got=%h/%h want=%h/%h",
                   a_pc, a_word, exp_pc, img[exp_pc[9:2]]);
        end
        n1 = exp_pc + 4;
        n2 = exp_pc + 8;
        a_br = 0;
        if (nbr < 5 && $urandom_range(0, 5) == 0
            && img[n1[9:2]] != HALT && img[n2[9:2]] != HALT) begin
          tgt = 32'($urandom_range(0, len - 1)) << 2;
          a_br = 1; a_tgt = tgt; nbr++;
          exp_pc = tgt;
        end else begin
          exp_pc = n1;
        end
      end
      hold = a_valid && !a_ready;
      hp = a_pc; hw = a_word;
      tick();
    end
    a_br = 0;
    total++;
    if (!fin || img[exp_pc[9:2]] !== HALT) begin
      bad++;
      $display("FAIL rnd_end got=fin:%b next:%h want=1/ffffffff",
               fin, img[exp_pc[9:2]]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    test_async_reset();
    for (int r = 0; r < 4; r++) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
